spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
Wishbone-side SPI master engine that drives the team's multi-slave SPI bus (ss, sck, mosi, miso) on the bench and in the simple_spi_wb environment. It accepts one DATA_W-bit word per valid/ready command, performs a full-duplex SPI transfer in any of the four CPOL/CPHA modes at a programmable divided rate, and returns the received word with a one-cycle rx_valid strobe. It sits directly upstream of the SPI interface and slave models, and directly downstream of the register/bus front end.

Parameters:
SLAVE_C, 1, number of slave-select lines (ss width)
DATA_W, 8, bits per transfer
DIV_W, 8, width of clock divider input

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
tx_data  input  DATA_W  word to transmit
tx_valid  input  1  command request
tx_ready  output  1  engine idle, command accepted when tx_valid && tx_ready
slave_sel  input  $clog2(SLAVE_C)+1  index of slave to select
cpol  input  1  sck idle level
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
clk_div  input  DIV_W  half-period = clk_div+1 clk cycles
rx_data  output  DATA_W  last received word
rx_valid  output  1  one-cycle strobe, rx_data updated
busy  output  1  transfer in progress (not IDLE)
ss  output  SLAVE_C  active-low slave selects
sck  output  1  SPI clock
mosi  output  1  master out
miso  input  1  master in

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values, from any state including mid-transfer: state IDLE, ss all ones, sck 0, latched cpol 0, mosi 0, rx_data 0, rx_valid 0, busy 0, tx_ready 1. A partial transfer is discarded and no rx_valid is issued.
- Command latch: on accept, latch tx_data, slave_sel, cpol, cpha and clk_div. Input changes during a transfer have no effect.
- FSM IDLE -> SETUP -> XFER -> HOLD -> IDLE. All outputs are registered.
- IDLE:
  - ss all ones; sck = latched cpol; tx_ready=1; busy=0.
  - On accept, go to SETUP next cycle.
- SETUP, one half-period:
  - ss[slave_sel]=0 and all other ss bits 1.
  - If slave_sel >= SLAVE_C, ss stays all ones and the transfer still runs.
  - CPHA=0: MSB is driven on mosi at SETUP entry.
- XFER, 2*DATA_W half-periods:
  - sck toggles at the end of each half-period.
  - Bit order is MSB first.
  - CPHA=0: miso is sampled on leading (odd) edges; mosi shifts on trailing edges, except after the last edge.
  - CPHA=1: mosi shifts on leading edges, with the first leading edge presenting the MSB; miso is sampled on trailing edges.
  - After the final edge, sck equals cpol.
- HOLD: one half-period with ss still asserted. Then go to IDLE. On IDLE entry, ss deasserts, rx_data is loaded and rx_valid pulses for 1 cycle.
- Latency: rx_valid is asserted (2*DATA_W+2)*(clk_div+1)+1 cycles after the accept edge.
- Back-to-back commands: tx_ready=1 in the rx_valid cycle. A command accepted in that cycle is legal; ss is high for at least that cycle.
- clk_div=0 gives sck at clk/2. clk_div = all ones gives half-period 2^DIV_W.
- Half-period counter: counts 0..clk_div then wraps. The bit counter is $clog2(2*DATA_W)+1 bits wide with no overflow.
- miso may be 'x' (bus contention or no driver). The sampled value is stored as is; the engine must not hang.

Optional Feature:
SPI_MASTER_LSB_FIRST_EN
- Defined: adds input port lsb_first (1 bit), latched on accept. When lsb_first=1, the word is shifted out and assembled LSB first; when 0, behaviour is MSB first as above.
- Undefined: the port is absent and the engine is MSB first only.

Test Plan:
- Mode 0 (cpol=0, cpha=0), clk_div=1, SLAVE_C=2, slave_sel=1, tx_data=8'hA5, slave returns 8'h3C -> ss=2'b01 during the transfer; mosi bits 1,0,1,0,0,1,0,1 sampled on rising sck; rx_valid at cycle 37 after accept with rx_data=8'h3C; ss returns to 2'b11.
- Modes 1, 2 and 3 each with tx_data=8'h81, slave echo model -> rx_data=8'h81; sck idles at cpol before and after; exactly 8 sck pulses per transfer.
- Back-to-back: tx_valid held high with 3 words 8'h01, 8'h02, 8'h03, clk_div=0 -> three rx_valid pulses; ss high for ≥1 cycle between words; no dropped or duplicated words.
- Reset mid-transfer: assert rst after 4 sck edges -> next cycle ss=all ones, sck=0, busy=0, no rx_valid; next command completes normally.
- slave_sel=2 with SLAVE_C=2 -> ss stays 2'b11, full transfer timing unchanged, rx_valid still issued.
- With SPI_MASTER_LSB_FIRST_EN and lsb_first=1, tx_data=8'h01 -> mosi 1 on the first sampled edge then 0s; slave sending 8'h80 LSB first yields rx_data=8'h80.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: full-duplex SPI master engine, one DATA_W-bit word per valid/ready command.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   tx_data/tx_valid     command word and request; accepted when tx_valid && tx_ready
//   tx_ready             engine idle
//   slave_sel            slave index (out-of-range index runs the transfer with no ss asserted)
//   cpol, cpha, clk_div  SPI mode and half-period (clk_div+1 clk cycles), latched on accept
//   rx_data/rx_valid     received word and its one-cycle strobe
//   busy                 transfer in progress
//   ss, sck, mosi, miso  SPI bus (ss active low)
//
// Build option: define SPI_MASTER_LSB_FIRST_EN to add input lsb_first (latched on accept);
// when set the word is shifted out and assembled LSB first.
module spi_master #(
    parameter int unsigned SLAVE_C = 1,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DIV_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [$clog2(SLAVE_C):0] slave_sel,
    input  logic                     cpol,
    input  logic                     cpha,
    input  logic [DIV_W-1:0]         clk_div,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic                     lsb_first,
`endif
    output logic [DATA_W-1:0]        rx_data,
    output logic                     rx_valid,
    output logic                     busy,
    output logic [SLAVE_C-1:0]       ss,
    output logic                     sck,
    output logic                     mosi,
    input  logic                     miso
);

    localparam int unsigned SelW = $clog2(SLAVE_C) + 1;
    localparam int unsigned BitW = $clog2(2 * DATA_W) + 1;

    typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

    state_e             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   hcnt_q;
    logic [BitW-1:0]    bcnt_q;     // sck edges already issued in this transfer
    logic               lead_q;     // one-cycle command latch slot at the start of SETUP
    logic               cpol_q;
    logic               cpha_q;
    logic               lsb_q;
    logic [DATA_W-1:0]  tx_sh_q;    // bits not yet presented on mosi
    logic [DATA_W-1:0]  rx_sh_q;
    logic [DATA_W-1:0]  rx_data_q;
    logic [SLAVE_C-1:0] ss_q;
    logic               sck_q;
    logic               mosi_q;
    logic               rx_valid_q;
    logic               busy_q;
    logic               tx_ready_q;

    logic               accept;
    logic               hp_end;
    logic               leading;
    logic               last_edge;
    logic               do_sample;
    logic               do_shift;
    logic               lsb_in;
    logic [SLAVE_C-1:0] ss_dec;

    function automatic logic head(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] drop(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] rx_in(input logic [DATA_W-1:0] w, input logic b,
                                                input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    always_comb begin
        accept    = (state_q == StIdle) && tx_valid && tx_ready_q;
        hp_end    = (hcnt_q == div_q);
        // Edges alternate leading/trailing starting with leading (bcnt_q even).
        leading   = ~bcnt_q[0];
        last_edge = (bcnt_q == BitW'(2 * DATA_W - 1));
        do_sample = cpha_q ? ~leading : leading;
        do_shift  = cpha_q ? leading : (~leading && ~last_edge);
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_in    = lsb_first;
`else
        lsb_in    = 1'b0;
`endif
        for (int i = 0; i < SLAVE_C; i++) begin
            ss_dec[i] = (slave_sel != SelW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            hcnt_q     <= '0;
            bcnt_q     <= '0;
            lead_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            ss_q       <= '1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q    <= StSetup;
                        div_q      <= clk_div;
                        cpol_q     <= cpol;
                        cpha_q     <= cpha;
                        lsb_q      <= lsb_in;
                        hcnt_q     <= '0;
                        bcnt_q     <= '0;
                        lead_q     <= 1'b1;
                        rx_sh_q    <= '0;
                        ss_q       <= ss_dec;
                        sck_q      <= cpol;
                        busy_q     <= 1'b1;
                        tx_ready_q <= 1'b0;
                        if (!cpha) begin
                            mosi_q  <= head(tx_data, lsb_in);
                            tx_sh_q <= drop(tx_data, lsb_in);
                        end else begin
                            tx_sh_q <= tx_data;
                        end
                    end
                end
                StSetup: begin
                    if (lead_q) begin
                        lead_q <= 1'b0;
                    end else if (hp_end) begin
                        hcnt_q  <= '0;
                        state_q <= StXfer;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                StXfer: begin
                    if (hp_end) begin
                        hcnt_q <= '0;
                        sck_q  <= ~sck_q;
                        bcnt_q <= bcnt_q + 1'b1;
                        if (do_sample) begin
                            rx_sh_q <= rx_in(rx_sh_q, miso, lsb_q);
                        end
                        if (do_shift) begin
                            mosi_q  <= head(tx_sh_q, lsb_q);
                            tx_sh_q <= drop(tx_sh_q, lsb_q);
                        end
                        if (last_edge) begin
                            state_q <= StHold;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                StHold: begin
                    if (hp_end) begin
                        hcnt_q     <= '0;
                        state_q    <= StIdle;
                        ss_q       <= '1;
                        rx_data_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                        busy_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign ss       = ss_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master (SLAVE_C=2, DATA_W=8, DIV_W=8).
// A cycle-level timing model (cycles since accept, half-period H) predicts ss, sck, busy,
// tx_ready, rx_valid and rx_data every cycle; an SPI slave model drives miso and captures mosi.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [1:0] slave_sel = '0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] clk_div = '0;
    logic       lsb_first = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic [1:0] ss;
    logic       sck;
    logic       mosi;
    logic       miso;

    spi_master #(
        .SLAVE_C (2),
        .DATA_W  (8),
        .DIV_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .slave_sel (slave_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .clk_div   (clk_div),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .ss        (ss),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: no event within cycle budget (t=%0t)", name, $time);
    endfunction

    // ---------------- timing model ----------------
    int         cyc = 0;
    int         acc_cnt = 0;
    int         m_acc_cyc = 0;
    bit         m_have = 1'b0;
    int         m_t = 0;
    int         m_h = 1;
    bit         m_cpol = 1'b0;
    bit         m_cpha = 1'b0;
    bit         m_lsb = 1'b0;
    logic [1:0] m_sel = '0;
    logic [7:0] m_word = '0;   // word the slave sends this transfer
    logic [7:0] m_tx = '0;     // word the master should send
    logic [7:0] m_rx = '0;
    logic [7:0] slave_word = '0;

    always @(posedge clk) begin : model
        bit rdy;
        cyc++;
        rdy = !(m_have && m_t <= 18 * m_h);
        if (rst) begin
            m_have = 1'b0;
            m_cpol = 1'b0;
            m_rx   = '0;
        end else if (tx_valid && rdy) begin
            m_have    = 1'b1;
            m_t       = 0;
            m_h       = int'(clk_div) + 1;
            m_cpol    = cpol;
            m_cpha    = cpha;
            m_lsb     = lsb_first;
            m_sel     = slave_sel;
            m_word    = slave_word;
            m_tx      = tx_data;
            m_acc_cyc = cyc;
            acc_cnt++;
        end else if (m_have) begin
            m_t++;
            if (m_t == 18 * m_h + 1) m_rx = m_word;
        end
    end

    // ---------------- slave model + per-cycle compare ----------------
    int         seen_acc = 0;
    int         s_n = 0;
    logic [7:0] s_cap = '0;
    logic       s_prev = 1'b0;
    logic [7:0] rx_q[$];

    function automatic logic sbit(input int i);
        return m_lsb ? m_word[i] : m_word[7-i];
    endfunction

    always @(negedge clk) begin : mon
        int   n;
        int   k;
        bit   act;
        logic [1:0] e_ss;
        if (acc_cnt != seen_acc) begin
            seen_acc = acc_cnt;
            s_n      = 0;
            s_cap    = '0;
            s_prev   = sck;
            miso     = sbit(0);
        end else if (sck !== s_prev) begin
            s_prev = sck;
            s_n++;
            if ((s_n % 2 == 1) != m_cpha) begin
                k = m_cpha ? s_n / 2 - 1 : (s_n - 1) / 2;
                if (k >= 0 && k < 8) s_cap[m_lsb ? k : 7 - k] = mosi;
            end
            if (!m_cpha && s_n % 2 == 0 && s_n < 16) miso = sbit(s_n / 2);
            if (m_cpha && s_n % 2 == 1 && s_n < 16) miso = sbit((s_n - 1) / 2);
        end
        if (chk_en) begin
            act = m_have && (m_t <= 18 * m_h);
            if (!m_have || m_t < 1) n = 0;
            else n = (m_t - 1) / m_h - 1;
            if (n < 0) n = 0;
            if (n > 16) n = 16;
            e_ss = (act && m_sel < 2) ? ~(2'b01 << m_sel) : 2'b11;
            chk("ss", ss, e_ss);
            chk("sck", sck, m_cpol ^ (n % 2 == 1));
            chk("busy", busy, act);
            chk("tx_ready", tx_ready, !act);
            chk("rx_valid", rx_valid, m_have && m_t == 18 * m_h + 1);
            chk("rx_data", rx_data, m_rx);
            if (m_have && m_t == 18 * m_h + 1) begin
                chk("slave_got_mosi", s_cap, m_tx);
                chk("sck_edge_count", s_n, 16);
            end
            if (rx_valid === 1'b1) rx_q.push_back(rx_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [7:0] d, input logic [7:0] sw, input logic [1:0] sel,
                         input logic p, input logic h, input logic [7:0] div,
                         input logic lsb, input bit hold);
        int seen;
        int k;
        seen       = acc_cnt;
        tx_data    = d;
        slave_word = sw;
        slave_sel  = sel;
        cpol       = p;
        cpha       = h;
        clk_div    = div;
        lsb_first  = lsb;
        tx_valid   = 1'b1;
        k = 0;
        while (acc_cnt == seen && k < 6000) begin
            @(negedge clk);
            k++;
        end
        if (acc_cnt == seen) timeout_fail("accept");
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_rv(output int lat);
        lat = -1;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                lat = cyc - m_acc_cyc;
                break;
            end
        end
        if (lat < 0) timeout_fail("rx_valid");
    endtask

    initial begin
        int lat;
        int k;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ss", ss, 2'b11);
        chk("rst_sck", sck, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0, slave 1, div 1
        issue(8'hA5, 8'h3C, 2'd1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("m0_ss_during", ss, 2'b01);
        wait_rv(lat);
        chk("m0_latency", lat, 37);
        chk("m0_rx", rx_data, 8'h3C);
        chk("m0_mosi_bits", s_cap, 8'hA5);
        @(negedge clk);
        chk("m0_ss_after", ss, 2'b11);

        // Modes 1..3 with echo slave
        for (int m = 1; m < 4; m++) begin
            issue(8'h81, 8'h81, 2'd0, m[1], m[0], 8'd2, 1'b0, 1'b0);
            chk("mode_sck_start", sck, m[1]);
            wait_rv(lat);
            chk("mode_rx", rx_data, 8'h81);
            chk("mode_edges", s_n, 16);
            @(negedge clk);
            chk("mode_sck_idle", sck, m[1]);
        end

        // Back-to-back with tx_valid held
        rx_q.delete();
        issue(8'h01, 8'h01, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        issue(8'h02, 8'h02, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        issue(8'h03, 8'h03, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        wait_rv(lat);
        repeat (3) @(negedge clk);
        chk("b2b_count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            chk("b2b_w0", rx_q[0], 8'h01);
            chk("b2b_w1", rx_q[1], 8'h02);
            chk("b2b_w2", rx_q[2], 8'h03);
        end

        // Reset mid-transfer (mode 2, so sck is high when idle before reset)
        issue(8'h5A, 8'hC3, 2'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
        k = 0;
        while (s_n < 4 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (s_n < 4) timeout_fail("four_sck_edges");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ss", ss, 2'b11);
        chk("mid_rst_sck", sck, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rx_valid", rx_valid, 1'b0);
        repeat (40) @(negedge clk);
        issue(8'h5A, 8'hC3, 2'd0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
        wait_rv(lat);
        chk("post_rst_rx", rx_data, 8'hC3);

        // Out-of-range slave select
        issue(8'h3C, 8'h96, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sel2_ss", ss, 2'b11);
        wait_rv(lat);
        chk("sel2_latency", lat, 19);
        chk("sel2_rx", rx_data, 8'h96);

        // Maximum divider, mode 3
        issue(8'hC6, 8'h6C, 2'd0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        wait_rv(lat);
        chk("maxdiv_latency", lat, 4609);
        chk("maxdiv_rx", rx_data, 8'h6C);

`ifdef SPI_MASTER_LSB_FIRST_EN
        issue(8'h01, 8'h80, 2'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
        wait_rv(lat);
        chk("lsb_mosi", s_cap, 8'h01);
        chk("lsb_rx", rx_data, 8'h80);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
